rv32_test_ctrl: RTL
===================

# rv32_test_ctrl

Synthesisable test-sequencing controller for the RV32 core bench and FPGA self-test builds. It generates the core's active-low reset sequence and supports repeated runs with re-reset between them. It snoops core data-bus stores to a tohost address to decide pass/fail, and enforces a cycle-count watchdog. It sits beside `rv32_top`, driving its `rst_n_i` and observing its store port, so directed tests end on a verdict rather than a fixed simulation time.

## Interface

Parameters:
- `TOHOST_ADDR`, 32'h0000_1000: store address treated as the test-status mailbox
- `RST_CYCLES`, 2: cycles `core_rst_n_o` is held low per run (≥1)
- `TIMEOUT_CYCLES`, 1004: maximum cycles per run before watchdog verdict (≥1, < 2^CNT_W)
- `NUM_RUNS`, 1: number of back-to-back runs, each preceded by a core reset (1..255)
- `CNT_W`, 32: cycle counter width

Ports:
- `clk_sys_i`  in  1  system clock; one clock domain.
- `rst_i`  in  1  synchronous reset, active-high.
- `bus_we_i`  in  1  core store strobe, one cycle per store
- `bus_addr_i`  in  32  store address
- `bus_wdata_i`  in  32  store data
- `core_rst_n_o`  out  1  active-low reset to core
- `cycle_cnt_o`  out  CNT_W  cycles elapsed in current run
- `run_idx_o`  out  8  index of current run, 0-based
- `done_o`  out  1  verdict reached, sticky
- `pass_o`  out  1  all runs passed
- `fail_o`  out  1  a run reported failure
- `timeout_o`  out  1  watchdog expired
- `fail_code_o`  out  31  `bus_wdata_i[31:1]` of the failing store

## Operation

- States: `HOLD`, `RUN`, `DONE`. Reset state is `HOLD` with the hold counter at 0.
- `HOLD`:
  - `core_rst_n_o`=0; hold counter increments each cycle.
  - At count `RST_CYCLES-1`, go to `RUN`, clear `cycle_cnt_o` and drive `core_rst_n_o`=1.
- `RUN`:
  - `cycle_cnt_o` increments every cycle, saturating at all-ones.
  - A tohost store is `bus_we_i`=1 and `bus_addr_i`=`TOHOST_ADDR`.
    - Data 1: pass for this run. If `run_idx_o`<`NUM_RUNS-1`, increment `run_idx_o` and return to `HOLD` (counter 0). Otherwise go to `DONE` with `pass_o`=1.
    - Data odd and ≠1: go to `DONE` with `fail_o`=1 and `fail_code_o`=data[31:1].
    - Data even: ignored (console traffic).
  - Stores to other addresses are ignored.
- `DONE`:
  - `core_rst_n_o`=0 (core frozen); `cycle_cnt_o`, `run_idx_o` and the verdict are held.
  - Exit only via `rst_i`.
- Stores are ignored in `HOLD` and `DONE`.
- Exactly one of `pass_o`/`fail_o`/`timeout_o` is set whenever `done_o`=1. All four are 0 while `done_o`=0.

## Timing

- Reset values: `core_rst_n_o`=0, `cycle_cnt_o`=0, `run_idx_o`=0, `done_o`=`pass_o`=`fail_o`=`timeout_o`=0, `fail_code_o`=0.
- All outputs are registered.
- `core_rst_n_o` is low for exactly `RST_CYCLES` edges after the first edge with `rst_i`=0. The same length applies to every re-reset between runs.
- `cycle_cnt_o`=0 on the first cycle `core_rst_n_o`=1.
- Verdict latency: a store sampled at edge N gives `done_o` and the verdict flag high after edge N; the same edge drives `core_rst_n_o` low.
- Watchdog: in `RUN`, if `cycle_cnt_o`=`TIMEOUT_CYCLES-1` with no tohost store that cycle, go to `DONE` with `timeout_o`=1. A run therefore lasts at most `TIMEOUT_CYCLES` cycles.
- Tohost store on the same cycle as watchdog expiry: the store wins.
- `rst_i` in any state, mid-run included, returns every output to its reset value on the next edge and restarts from run 0.

## Configuration

- `RV32_TEST_CTRL_WATCHDOG_EN`:
  - Defined: watchdog active as above.
  - Undefined: no timeout logic. `timeout_o` is tied 0 and `RUN` ends only on a pass/fail store. `cycle_cnt_o` still counts and saturates.

## Test plan

- Defaults, no stores: `core_rst_n_o` low for 2 cycles after `rst_i` falls, then high for 1004 cycles. Then `done_o`=`timeout_o`=1, `cycle_cnt_o`=1003, `core_rst_n_o`=0.
- Store 32'h1 to 32'h1000 at `cycle_cnt_o`=50: next cycle `done_o`=`pass_o`=1, `cycle_cnt_o` holds 50. A store of 32'h2 earlier changes nothing.
- Store 32'h7 to 32'h1000: `fail_o`=1, `fail_code_o`=3. Stores of 32'h1 to 32'h1004 are ignored.
- `NUM_RUNS`=3, pass store each run: `core_rst_n_o` pulses low 2 cycles between runs, `run_idx_o` steps 0→1→2, then `pass_o`=1. A fail store in run 1 gives `fail_o`=1 with `run_idx_o`=1.
- Pass store exactly at `cycle_cnt_o`=1003: `pass_o`=1, `timeout_o`=0.
- `rst_i` pulsed for 1 cycle at `cycle_cnt_o`=200 in run 1: all outputs return to reset values and the sequence restarts at run 0. Repeat with the macro undefined: no timeout after 2000 cycles.

Source files
------------

// File: rtl/rv32_test_ctrl.sv
// Test-sequencing controller: core reset sequencing, tohost pass/fail snooping, run watchdog.
// Define RV32_TEST_CTRL_WATCHDOG_EN to enable the cycle-count watchdog.
module rv32_test_ctrl #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1004,
  parameter int unsigned NUM_RUNS       = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_sys_i,
  input  logic             rst_i,
  input  logic             bus_we_i,
  input  logic [31:0]      bus_addr_i,
  input  logic [31:0]      bus_wdata_i,
  output logic             core_rst_n_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [7:0]       run_idx_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [30:0]      fail_code_o
);

  typedef enum logic [1:0] {StHold, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [7:0]       run_idx_q, run_idx_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             timeout_q, timeout_d;
  logic [30:0]      fail_code_q, fail_code_d;
  logic             tohost;

  assign tohost = bus_we_i && (bus_addr_i == TOHOST_ADDR);

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    run_idx_d    = run_idx_q;
    core_rst_n_d = core_rst_n_q;
    done_d       = done_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    fail_code_d  = fail_code_q;
    unique case (state_q)
      StHold: begin
        core_rst_n_d = 1'b0;
        hold_cnt_d   = hold_cnt_q + 32'd1;
        if (hold_cnt_q == 32'(RST_CYCLES - 1)) begin
          state_d      = StRun;
          hold_cnt_d   = '0;
          cycle_cnt_d  = '0;
          core_rst_n_d = 1'b1;
        end
      end
      StRun: begin
        if (tohost && (bus_wdata_i == 32'd1)) begin
          core_rst_n_d = 1'b0;
          if (run_idx_q < 8'(NUM_RUNS - 1)) begin
            run_idx_d  = run_idx_q + 8'd1;
            hold_cnt_d = '0;
            state_d    = StHold;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end
        end else if (tohost && bus_wdata_i[0]) begin
          core_rst_n_d = 1'b0;
          state_d      = StDone;
          done_d       = 1'b1;
          fail_d       = 1'b1;
          fail_code_d  = bus_wdata_i[31:1];
`ifdef RV32_TEST_CTRL_WATCHDOG_EN
        end else if (cycle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          core_rst_n_d = 1'b0;
          state_d      = StDone;
          done_d       = 1'b1;
          timeout_d    = 1'b1;
`endif
        end else if (cycle_cnt_q != '1) begin
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        core_rst_n_d = 1'b0;
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state_q      <= StHold;
      hold_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      run_idx_q    <= '0;
      core_rst_n_q <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      fail_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      run_idx_q    <= run_idx_d;
      core_rst_n_q <= core_rst_n_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      fail_code_q  <= fail_code_d;
    end
  end

  assign core_rst_n_o = core_rst_n_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign run_idx_o    = run_idx_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign timeout_o    = timeout_q;
  assign fail_code_o  = fail_code_q;

endmodule
